div: RTL and testbench

- Sequential signed 32-bit integer divider; the divide counterpart of the multi-cycle multiplier in the ALU/HI-LO datapath.
- Uses the same start-pulse / done-pulse handshake as the multiplier.
- Writes the quotient to low and the remainder to high (MIPS DIV semantics), so the control unit loads HI/LO the same way for both operations.
- Uses an iterative restoring algorithm on magnitudes, followed by a sign-correction cycle.

---
 rtl/div.sv | 103 ++++++++++
 tb/tb_div.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/div.sv
// Sequential signed divider: restoring division on magnitudes, one bit per cycle,
// then a sign-correction cycle. Quotient goes to low, remainder to high.
module div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] high,
    output logic [WIDTH-1:0] low,
    output logic             div_end,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = 1;

    state_t           state, state_nx;
    logic             sa, sb;
    logic [WIDTH-1:0] mag_b, rem, quo;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] mag_a_in, mag_b_in, rem_nx, quo_nx;
    logic [WIDTH:0]   rem_sh, trial;

    always_comb begin
        mag_a_in = a[WIDTH-1] ? (~a + ONE) : a;
        mag_b_in = b[WIDTH-1] ? (~b + ONE) : b;
    end

    // One restoring step: the dividend's MSB shifts out of quo into rem.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {1'b0, mag_b};
        rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (DivCtrl) begin
            state_nx = (b == '0) ? ZERO : RUN;
        end else begin
            case (state)
                RUN:     if (count == CW'(1)) state_nx = FIX;
                FIX:     state_nx = IDLE;
                ZERO:    state_nx = IDLE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sa       <= 1'b0;
            sb       <= 1'b0;
            mag_b    <= '0;
            rem      <= '0;
            quo      <= '0;
            count    <= '0;
            high     <= '0;
            low      <= '0;
            div_end  <= 1'b0;
            div_zero <= 1'b0;
        end else if (DivCtrl) begin
            // A start in any state restarts from scratch.
            sa       <= a[WIDTH-1];
            sb       <= b[WIDTH-1];
            mag_b    <= mag_b_in;
            quo      <= mag_a_in;
            rem      <= '0;
            count    <= CW'(WIDTH);
            div_end  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    rem   <= rem_nx;
                    quo   <= quo_nx;
                    count <= count - CW'(1);
                end
                FIX: begin
                    low     <= (sa ^ sb) ? (~quo + ONE) : quo;
                    high    <= sa ? (~rem + ONE) : rem;
                    div_end <= 1'b1;
                end
                ZERO: begin
                    div_zero <= 1'b1;
                    div_end  <= 1'b1;
                end
                default: div_end <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: expected results are queued at start and checked on div_end.
module tb_div;
    logic        clk = 0, reset = 1, DivCtrl = 0;
    logic [31:0] a = 0, b = 0;
    logic [31:0] high, low;
    logic        div_end, div_zero;

    div #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .DivCtrl(DivCtrl), .a(a), .b(b),
        .high(high), .low(low), .div_end(div_end), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
        int          start;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        got;
    int          cyc = 0, n_chk = 0, n_fail = 0;
    logic [31:0] mdl_hi = 0, mdl_lo = 0, ra, rb;
    logic        prev_end = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (div_end) begin
            chk("end_width", {31'b0, prev_end}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("spurious_end", 32'd1, 32'd0);
            end else begin
                got = sb_q.pop_front();
                chk("low", low, got.lo);
                chk("high", high, got.hi);
                chk("div_zero", {31'b0, div_zero}, {31'b0, got.zero});
                chk("latency", cyc - got.start, got.lat);
            end
        end
        prev_end <= div_end;
    end

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            chk("timeout", 32'd1, 32'd0);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_div(input logic [31:0] av, input logic [31:0] bv, input int hold);
        exp_t   e;
        longint la, lb, q, r;
        la = longint'($signed(av));
        lb = longint'($signed(bv));
        if (bv == 0) begin
            e.lo = mdl_lo; e.hi = mdl_hi; e.zero = 1'b1; e.lat = 1;
        end else begin
            q = la / lb;
            r = la % lb;
            e.lo = q[31:0]; e.hi = r[31:0]; e.zero = 1'b0; e.lat = 33;
            mdl_lo = e.lo; mdl_hi = e.hi;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a = av; b = bv; DivCtrl = 1;
        end
        e.start = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        DivCtrl = 0;
        wait_drain();
    endtask

    initial begin
        #2 reset = 0;
        repeat (3) @(negedge clk);
        chk("rst_high", high, 32'd0);
        chk("rst_low", low, 32'd0);
        chk("rst_end", {31'b0, div_end}, 32'd0);
        chk("rst_zero", {31'b0, div_zero}, 32'd0);
        reset = 1;
        @(negedge clk);

        do_div(32'd7, 32'd2, 1);
        do_div(32'hFFFFFFF9, 32'd2, 1);
        do_div(32'd7, 32'hFFFFFFFE, 1);

        do_div(32'd100, 32'd0, 1);
        repeat (5) @(negedge clk);
        chk("zero_hold", {31'b0, div_zero}, 32'd1);
        chk("zero_keep_low", low, mdl_lo);
        chk("zero_keep_high", high, mdl_hi);

        do_div(32'h80000000, 32'hFFFFFFFF, 1);
        do_div(32'h80000000, 32'd3, 1);
        do_div(32'd100, 32'd7, 3);
        do_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 0) rb = 32'd5;
            do_div(ra, rb, 1);
        end

        // Reset in the middle of a run: outputs clear at once, no done pulse.
        @(negedge clk);
        a = 32'd7; b = 32'd2; DivCtrl = 1;
        @(negedge clk);
        DivCtrl = 0;
        repeat (10) @(negedge clk);
        reset = 0;
        #1;
        chk("abort_low", low, 32'd0);
        chk("abort_high", high, 32'd0);
        chk("abort_end", {31'b0, div_end}, 32'd0);
        mdl_lo = 0; mdl_hi = 0;
        @(negedge clk);
        reset = 1;
        repeat (45) @(negedge clk);
        chk("abort_low_after", low, 32'd0);

        // Restart mid-run: only the second operation completes.
        @(negedge clk);
        a = 32'd7; b = 32'd2; DivCtrl = 1;
        @(negedge clk);
        DivCtrl = 0;
        repeat (9) @(negedge clk);
        do_div(32'd9, 32'd4, 1);
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
